// File: rtl/adder_access_arbiter.sv
// rtl/adder_access_arbiter.sv - round-robin arbiter sharing one multi-cycle adder between two requesters
module adder_access_arbiter #(
  parameter bit          APX_ACC_CONTROL = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_input_1,
  input  logic [31:0] req0_input_2,
  input  logic        req0_subtract,
  input  logic [7:0]  req0_accuracy,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_input_1,
  input  logic [31:0] req1_input_2,
  input  logic        req1_subtract,
  input  logic [7:0]  req1_accuracy,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_result,
  output logic        resp_error,
  output logic [31:0] adder_input_1,
  output logic [31:0] adder_input_2,
  output logic [7:0]  adder_accuracy,
  output logic        adder_start,
  input  logic        adder_done,
  input  logic [31:0] adder_result,
  output logic        busy
);

  // Counter must hold 0..TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rr_prio_q, rr_prio_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [7:0]    acc_q, acc_d;
  logic          start_q, start_d;
  logic          resp0_q, resp0_d;
  logic          resp1_q, resp1_d;
  logic [31:0]   result_q, result_d;
  logic          error_q, error_d;

  logic          grant;
  logic          accept;
  logic [31:0]   sel_in1;
  logic [31:0]   sel_in2;
  logic          sel_sub;
  logic [7:0]    sel_acc;
  logic          timeout_hit;

  // Arbitration: a lone valid requester wins, otherwise the round-robin pointer decides.
  always_comb begin
    grant = rr_prio_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
    req0_ready = (state_q == S_IDLE) && !grant;
    req1_ready = (state_q == S_IDLE) && grant;
    accept     = (state_q == S_IDLE) && (grant ? req1_valid : req0_valid);
    sel_in1    = grant ? req1_input_1  : req0_input_1;
    sel_in2    = grant ? req1_input_2  : req0_input_2;
    sel_sub    = grant ? req1_subtract : req0_subtract;
    sel_acc    = grant ? req1_accuracy : req0_accuracy;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIM);
  end

  // Sequencer next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    rr_prio_d = rr_prio_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    acc_d     = acc_q;
    start_d   = 1'b0;
    resp0_d   = 1'b0;
    resp1_d   = 1'b0;
    result_d  = result_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant;
          op1_d   = sel_in1;
          op2_d   = sel_sub ? (~sel_in2 + 32'd1) : sel_in2;
          acc_d   = APX_ACC_CONTROL ? sel_acc : 8'hFF;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adder_done) begin
          result_d = adder_result;
          error_d  = 1'b0;
          resp0_d  = !owner_q;
          resp1_d  = owner_q;
          state_d  = S_RESPOND;
        end else if (timeout_hit) begin
          result_d = 32'd0;
          error_d  = 1'b1;
          resp0_d  = !owner_q;
          resp1_d  = owner_q;
          state_d  = S_RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESPOND: begin
        rr_prio_d = !owner_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      rr_prio_q <= 1'b0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      acc_q     <= 8'd0;
      start_q   <= 1'b0;
      resp0_q   <= 1'b0;
      resp1_q   <= 1'b0;
      result_q  <= 32'd0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      rr_prio_q <= rr_prio_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      acc_q     <= acc_d;
      start_q   <= start_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  assign adder_input_1  = op1_q;
  assign adder_input_2  = op2_q;
  assign adder_accuracy = acc_q;
  assign adder_start    = start_q;
  assign resp0_valid    = resp0_q;
  assign resp1_valid    = resp1_q;
  assign resp_result    = result_q;
  assign resp_error     = error_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_access_arbiter.sv
// tb/tb_adder_access_arbiter.sv - directed self-checking bench for adder_access_arbiter
module tb_adder_access_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_input_1, req0_input_2, req1_input_1, req1_input_2;
  logic        req0_subtract, req1_subtract;
  logic [7:0]  req0_accuracy, req1_accuracy;
  logic        adder_done;
  logic [31:0] adder_result;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp_error;
  logic [31:0] resp_result, adder_input_1, adder_input_2;
  logic [7:0]  adder_accuracy;
  logic        adder_start, busy;

  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid, b_resp_error;
  logic [31:0] b_resp_result, b_adder_input_1, b_adder_input_2;
  logic [7:0]  b_adder_accuracy;
  logic        b_adder_start, b_busy;

  int checks;
  int errors;

  adder_access_arbiter #(.APX_ACC_CONTROL(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_input_1(req0_input_1), .req0_input_2(req0_input_2),
    .req0_subtract(req0_subtract), .req0_accuracy(req0_accuracy),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_input_1(req1_input_1), .req1_input_2(req1_input_2),
    .req1_subtract(req1_subtract), .req1_accuracy(req1_accuracy),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_error(resp_error),
    .adder_input_1(adder_input_1), .adder_input_2(adder_input_2),
    .adder_accuracy(adder_accuracy), .adder_start(adder_start),
    .adder_done(adder_done), .adder_result(adder_result), .busy(busy)
  );

  adder_access_arbiter #(.APX_ACC_CONTROL(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready),
    .req0_input_1(req0_input_1), .req0_input_2(req0_input_2),
    .req0_subtract(req0_subtract), .req0_accuracy(req0_accuracy),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready),
    .req1_input_1(req1_input_1), .req1_input_2(req1_input_2),
    .req1_subtract(req1_subtract), .req1_accuracy(req1_accuracy),
    .resp0_valid(b_resp0_valid), .resp1_valid(b_resp1_valid),
    .resp_result(b_resp_result), .resp_error(b_resp_error),
    .adder_input_1(b_adder_input_1), .adder_input_2(b_adder_input_2),
    .adder_accuracy(b_adder_accuracy), .adder_start(b_adder_start),
    .adder_done(adder_done), .adder_result(adder_result), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || adder_start !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b start=%b r0=%b r1=%b want 0 0 0 0", busy, adder_start, resp0_valid, resp1_valid);
    end
    checks++;
    if (resp_result !== 32'd0 || resp_error !== 1'b0 || adder_input_1 !== 32'd0 || adder_input_2 !== 32'd0 || adder_accuracy !== 8'd0) begin
      errors++;
      $display("FAIL reset_data res=%h err=%b in1=%h in2=%h acc=%h want zeros", resp_result, resp_error, adder_input_1, adder_input_2, adder_accuracy);
    end
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single_add();
    req0_valid = 1'b1; req0_input_1 = 32'd5; req0_input_2 = 32'd7; req0_subtract = 1'b0; req0_accuracy = 8'h20;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ready rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (adder_start !== 1'b1 || busy !== 1'b1 || adder_accuracy !== 8'h20 || adder_input_1 !== 32'd5 || adder_input_2 !== 32'd7) begin
      errors++;
      $display("FAIL add_issue start=%b busy=%b acc=%h in1=%h in2=%h want 1 1 20 5 7", adder_start, busy, adder_accuracy, adder_input_1, adder_input_2);
    end
    @(negedge clk);
    adder_done = 1'b1; adder_result = 32'd12;
    checks++;
    if (adder_start !== 1'b0 || resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_wait start=%b r0=%b want 0 0", adder_start, resp0_valid);
    end
    @(negedge clk);
    adder_done = 1'b0;
    checks++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_result !== 32'd12 || resp_error !== 1'b0) begin
      errors++;
      $display("FAIL add_resp r0=%b r1=%b res=%h err=%b want 1 0 c 0", resp0_valid, resp1_valid, resp_result, resp_error);
    end
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse r0=%b busy=%b want 0 0", resp0_valid, busy);
    end
  endtask

  task automatic test_subtract();
    req1_valid = 1'b1; req1_input_1 = 32'd3; req1_input_2 = 32'd5; req1_subtract = 1'b1; req1_accuracy = 8'h40;
    @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if (adder_input_1 !== 32'd3 || adder_input_2 !== 32'hFFFF_FFFB) begin
      errors++;
      $display("FAIL sub_operands in1=%h in2=%h want 3 fffffffb", adder_input_1, adder_input_2);
    end
    @(negedge clk);
    adder_done = 1'b1; adder_result = 32'hFFFF_FFFE;
    @(negedge clk);
    adder_done = 1'b0;
    checks++;
    if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sub_resp r0=%b r1=%b res=%h want 0 1 fffffffe", resp0_valid, resp1_valid, resp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_negate_bounds();
    logic [31:0] vin [2];
    logic [31:0] vexp [2];
    vin[0] = 32'h0000_0000; vexp[0] = 32'h0000_0000;
    vin[1] = 32'h8000_0000; vexp[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_input_1 = 32'd1; req0_input_2 = vin[i]; req0_subtract = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      checks++;
      if (adder_input_2 !== vexp[i]) begin
        errors++;
        $display("FAIL negate_%0d in2=%h want %h", i, adder_input_2, vexp[i]);
      end
      @(negedge clk);
      adder_done = 1'b1; adder_result = 32'd1;
      @(negedge clk);
      adder_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    int exp_owner;
    do_reset();
    req0_valid = 1'b1; req0_input_1 = 32'd10;  req0_input_2 = 32'd20; req0_subtract = 1'b0;
    req1_valid = 1'b1; req1_input_1 = 32'd100; req1_input_2 = 32'd50; req1_subtract = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_owner = i % 2;
      checks++;
      if (req0_ready !== (exp_owner == 0) || req1_ready !== (exp_owner == 1)) begin
        errors++;
        $display("FAIL rr_grant_%0d rdy0=%b rdy1=%b want owner %0d", i, req0_ready, req1_ready, exp_owner);
      end
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL rr_busy_ready_%0d rdy0=%b rdy1=%b want 0 0", i, req0_ready, req1_ready);
      end
      @(negedge clk);
      adder_done = 1'b1; adder_result = (exp_owner == 1) ? 32'd150 : 32'd30;
      @(negedge clk);
      adder_done = 1'b0;
      checks++;
      if (resp0_valid !== (exp_owner == 0) || resp1_valid !== (exp_owner == 1) || resp_result !== adder_result) begin
        errors++;
        $display("FAIL rr_resp_%0d r0=%b r1=%b res=%h want owner %0d res %h", i, resp0_valid, resp1_valid, resp_result, exp_owner, adder_result);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    req0_valid = 1'b1; req0_input_1 = 32'd8; req0_input_2 = 32'd8; req0_subtract = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (adder_start !== 1'b1) begin
      errors++;
      $display("FAIL to_issue start=%b want 1", adder_start);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (resp0_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL to_wait_%0d r0=%b busy=%b want 0 1", k, resp0_valid, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp_error !== 1'b1 || resp_result !== 32'd0) begin
      errors++;
      $display("FAIL to_resp r0=%b err=%b res=%h want 1 1 0", resp0_valid, resp_error, resp_result);
    end
    @(negedge clk);
    req1_valid = 1'b1; req1_input_1 = 32'd1; req1_input_2 = 32'd2; req1_subtract = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    adder_done = 1'b1; adder_result = 32'd3;
    @(negedge clk);
    adder_done = 1'b0;
    checks++;
    if (resp1_valid !== 1'b1 || resp_error !== 1'b0 || resp_result !== 32'd3) begin
      errors++;
      $display("FAIL to_recover r1=%b err=%b res=%h want 1 0 3", resp1_valid, resp_error, resp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    req0_valid = 1'b1; req0_input_1 = 32'd2; req0_input_2 = 32'd2; req0_subtract = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    adder_done = 1'b1; adder_result = 32'd4;
    @(negedge clk);
    adder_done = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || adder_start !== 1'b0 || adder_input_1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_async busy=%b start=%b in1=%h want 0 0 0", busy, adder_start, adder_input_1);
    end
    @(negedge clk);
    reset = 1'b0;
    adder_done = 1'b1; adder_result = 32'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0 || adder_start !== 1'b0) begin
        errors++;
        $display("FAIL rst_stray_%0d r0=%b r1=%b busy=%b start=%b want 0 0 0 0", k, resp0_valid, resp1_valid, busy, adder_start);
      end
    end
    adder_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_rr rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_acc_disabled();
    do_reset();
    adder_done = 1'b1; adder_result = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    checks++;
    if (b_resp0_valid !== 1'b0 || b_resp1_valid !== 1'b0 || b_busy !== 1'b0 || resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle r0=%b r1=%b busy=%b a_r0=%b want 0 0 0 0", b_resp0_valid, b_resp1_valid, b_busy, resp0_valid);
    end
    adder_done = 1'b0;
    req0_valid = 1'b1; req0_input_1 = 32'd9; req0_input_2 = 32'd1; req0_subtract = 1'b0; req0_accuracy = 8'h3C;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (b_adder_accuracy !== 8'hFF || adder_accuracy !== 8'h3C) begin
      errors++;
      $display("FAIL acc_ctrl b_acc=%h a_acc=%h want ff 3c", b_adder_accuracy, adder_accuracy);
    end
    @(negedge clk);
    adder_done = 1'b1; adder_result = 32'd10;
    @(negedge clk);
    adder_done = 1'b0;
    checks++;
    if (b_resp0_valid !== 1'b1 || b_resp_result !== 32'd10 || b_resp_error !== 1'b0) begin
      errors++;
      $display("FAIL acc_resp r0=%b res=%h err=%b want 1 a 0", b_resp0_valid, b_resp_result, b_resp_error);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_input_1 = 32'd0; req0_input_2 = 32'd0; req0_subtract = 1'b0; req0_accuracy = 8'd0;
    req1_input_1 = 32'd0; req1_input_2 = 32'd0; req1_subtract = 1'b0; req1_accuracy = 8'd0;
    adder_done = 1'b0; adder_result = 32'd0;
    test_reset();
    test_single_add();
    test_subtract();
    test_negate_bounds();
    test_contention();
    test_timeout();
    test_reset_in_wait();
    test_acc_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
